// File: rtl/bnn_acc_seq.sv
// Bit-serial binary neural network dot-product accumulator.
// One +/-1 term per cycle is applied to the accumulator through an external add1/sub1 ALU.
module bnn_acc_seq #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VEC_LEN-1:0]      act_vec,
    input  logic [VEC_LEN-1:0]      wgt_vec,
    input  logic signed [ACC_W-1:0] bias,
    output logic                    alu_a_lsb,
    output logic                    alu_op,
    output logic signed [ACC_W-1:0] alu_b,
    input  logic signed [ACC_W-1:0] alu_res,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_sign,
    output logic [1:0]              fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and out_valid/out_data hold until the transfer.
    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic [VEC_LEN-1:0]        act_q;
    logic [VEC_LEN-1:0]        wgt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a_lsb = 1'b0;
        alu_op    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                // A mismatching bit pair is a -1 term, so sub1; a match is +1, so add1.
                alu_a_lsb = 1'b1;
                alu_op    = act_q[cnt] ^ wgt_q[cnt];
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            act_q <= '0;
            wgt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        act_q <= act_vec;
                        wgt_q <= wgt_vec;
                        acc   <= bias;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= alu_res;
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign alu_b     = acc;
    assign out_data  = acc;
    assign out_sign  = ~acc[ACC_W-1];
    assign fsm_state = state;

endmodule

// File: tb/tb_bnn_acc_seq.sv
// Bench for bnn_acc_seq: directed and random operand sets scored against a +/-1 sum model.
module tb_bnn_acc_seq;

    localparam int VEC_LEN = 16;
    localparam int ACC_W   = 12;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [VEC_LEN-1:0]      act_vec = '0;
    logic [VEC_LEN-1:0]      wgt_vec = '0;
    logic signed [ACC_W-1:0] bias = '0;
    logic                    alu_a_lsb;
    logic                    alu_op;
    logic signed [ACC_W-1:0] alu_b;
    logic signed [ACC_W-1:0] alu_res;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_sign;
    logic [1:0]              fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [ACC_W:0] exp_q[$];

    bnn_acc_seq #(.VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .act_vec(act_vec), .wgt_vec(wgt_vec), .bias(bias),
        .alu_a_lsb(alu_a_lsb), .alu_op(alu_op), .alu_b(alu_b), .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sign(out_sign), .fsm_state(fsm_state)
    );

    // External ALU: add1 / sub1 of the step magnitude.
    assign alu_res = alu_op ? alu_b - ACC_W'(alu_a_lsb) : alu_b + ACC_W'(alu_a_lsb);

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Reference: sum of +1 per matching bit and -1 per mismatching bit, starting at bias.
    function automatic logic [ACC_W:0] model(input logic [VEC_LEN-1:0] a, input logic [VEC_LEN-1:0] w,
                                             input logic [ACC_W-1:0] b);
        int s;
        logic [ACC_W-1:0] r;
        s = int'($signed(b));
        for (int i = 0; i < VEC_LEN; i++) s += (a[i] == w[i]) ? 1 : -1;
        r = s[ACC_W-1:0];
        return {~r[ACC_W-1], r};
    endfunction

    // Monitor: pops one expectation per result handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(out_data), 32'hDEAD);
            end else begin
                logic [ACC_W:0] e;
                e = exp_q.pop_front();
                chk("result", {19'd0, out_sign, out_data}, {19'd0, e});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [VEC_LEN-1:0] a, input logic [VEC_LEN-1:0] w,
                          input logic [ACC_W-1:0] b, input int hold);
        int n;
        logic [ACC_W-1:0] held;
        wait_ready();
        in_valid = 1'b1; act_vec = a; wgt_vec = w; bias = b;
        exp_q.push_back(model(a, w, b));
        @(posedge clk); #1;
        // Inputs are scrambled while busy; they must not affect the result.
        n = 0;
        while (!out_valid && n < VEC_LEN + 5) begin
            in_valid = 1'($urandom); act_vec = VEC_LEN'($urandom);
            wgt_vec = VEC_LEN'($urandom); bias = ACC_W'($urandom);
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(VEC_LEN));
        held = out_data;
        in_valid = 1'b1;
        repeat (hold) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            chk("done_hold", {18'd0, out_valid, in_ready, fsm_state, held}, {18'd0, 1'b1, 1'b0, 2'd2, held});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bubble_after_handshake", {29'd0, in_ready, out_valid, fsm_state == 2'd0}, {29'd0, 3'b101});
    endtask

    initial begin
        int seen;
        #1;
        chk("reset_state", {13'd0, in_ready, out_valid, alu_a_lsb, alu_op, out_sign, fsm_state, out_data},
            {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 12'd0});
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run_op(16'hFFFF, 16'hFFFF, 12'd0, 0);
        run_op(16'hFFFF, 16'h0000, 12'd0, 1);
        run_op(16'h00FF, 16'h0000, 12'd0, 2);
        run_op(16'hAAAA, 16'h5555, 12'd5, 0);
        run_op(16'hFFFF, 16'hFFFF, 12'h7FF, 0);
        run_op(16'h0000, 16'hFFFF, 12'h800, 0);
        run_op(16'h1234, 16'h4321, 12'h123, 10);
        run_op(16'hC3C3, 16'h3C3C, 12'hFFE, 0);

        // Reset in the middle of RUN, with cnt at 7.
        wait_ready();
        in_valid = 1'b1; act_vec = 16'hFFFF; wgt_vec = 16'hFFFF; bias = 12'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); end
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_clear", {13'd0, in_ready, out_valid, alu_a_lsb, alu_op, out_sign, fsm_state, out_data},
            {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 12'd0});
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_output_after_reset", 32'(seen), 32'd0);
        @(posedge clk); #1;
        run_op(16'hF0F0, 16'hFF00, 12'd3, 1);

        for (int i = 0; i < 25; i++) begin
            run_op(VEC_LEN'($urandom), VEC_LEN'($urandom), ACC_W'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bnn_acc_seq.md
BNN_ACC_SEQ -- requirements
Module: bnn_acc_seq

Interface
REQ-001 SHALL have parameter VEC_LEN, default 16, meaning the number of input bits per dot product (legal range 1..2047).
REQ-002 SHALL have parameter ACC_W, default 12, meaning the accumulator width, matching the ALU datapath.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  an operand set is offered.
REQ-006 SHALL have port in_ready  output  1  the block accepts an operand set.
REQ-007 SHALL have port act_vec  input  VEC_LEN  binary activations; bit value 1 means +1, 0 means -1.
REQ-008 SHALL have port wgt_vec  input  VEC_LEN  binary weights with the same encoding.
REQ-009 SHALL have port bias  input  ACC_W signed  initial accumulator value.
REQ-010 SHALL have port alu_a_lsb  output  1  step magnitude driven to the ALU.
REQ-011 SHALL have port alu_op  output  1  ALU operation; 0 = add1, 1 = sub1.
REQ-012 SHALL have port alu_b  output  ACC_W signed  current accumulator driven to the ALU.
REQ-013 SHALL have port alu_res  input  ACC_W signed  combinational ALU result.
REQ-014 SHALL have port out_valid  output  1  a result is available.
REQ-015 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-016 SHALL have port out_data  output  ACC_W signed  final accumulator.
REQ-017 SHALL have port out_sign  output  1  binarised activation, equal to ~out_data[ACC_W-1].

Function
REQ-018 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-019 SHALL drive in_ready = 1 only in IDLE.
REQ-020 SHALL perform acceptance in IDLE when in_valid is 1: latch act_vec and wgt_vec, load acc <= bias, clear bit counter cnt <= 0, go to RUN.
REQ-021 SHALL drive the ALU in RUN as follows: alu_a_lsb = 1; alu_op = add1 if act[cnt] XNOR wgt[cnt] is 1, otherwise sub1; processing order is LSB first.
REQ-022 SHALL, on each RUN edge, update acc <= alu_res and cnt <= cnt + 1; on the edge where cnt == VEC_LEN-1, go to DONE.
REQ-023 SHALL, outside RUN, drive alu_a_lsb = 0 and alu_op = add1 so that alu_res equals alu_b.
REQ-024 SHALL drive alu_b = acc at all times.
REQ-025 SHALL hold acc in IDLE and DONE.
REQ-026 SHALL assert out_valid exactly VEC_LEN cycles after the acceptance edge, with out_data = acc.
REQ-027 SHALL hold out_valid and out_data stable in DONE until out_ready is 1; then return to IDLE on that edge.
REQ-028 SHALL insert at least one bubble between back-to-back operations: no acceptance in DONE, and in_ready rises the cycle after the result handshake.
REQ-029 SHALL ignore in_valid, act_vec, wgt_vec and bias outside IDLE; latched vectors are immune to input changes after acceptance.
REQ-030 SHALL NOT saturate; arithmetic is two's-complement wrap at ACC_W bits, as performed by the ALU.
REQ-031 SHALL support VEC_LEN = 1: a single RUN cycle, then DONE.
REQ-032 SHALL drive out_data = acc continuously; it is valid only while out_valid is 1.

Reset
REQ-033 SHALL, on rst = 1 at any time including mid-RUN or in DONE, immediately force: state = IDLE, acc = 0, cnt = 0, latched vectors = 0, out_valid = 0, in_ready = 1 after release, alu_a_lsb = 0, alu_op = add1, out_data = 0, out_sign = 1.
REQ-034 SHALL discard any in-flight operation on reset, with no partial result emitted.

Verification
REQ-035 SHALL be verified with VEC_LEN=16, act=16'hFFFF, wgt=16'hFFFF, bias=0 -> out_valid 16 cycles after accept; out_data=16; out_sign=1.
REQ-036 SHALL be verified with act=16'hFFFF, wgt=16'h0000, bias=0 -> out_data=-16 (12'hFF0); out_sign=0.
REQ-037 SHALL be verified with act=16'h00FF, wgt=16'h0000, bias=0 -> 8 matches and 8 mismatches; out_data=0; out_sign=1.
REQ-038 SHALL be verified with act=16'hAAAA, wgt=16'h5555, bias=5 -> out_data=-11 (12'hFF5).
REQ-039 SHALL be verified with out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle; a second operand set is accepted with one bubble.
REQ-040 SHALL be verified with rst asserted at cnt=7 -> asynchronous clear to IDLE, out_valid never asserted; a new operation afterwards produces a correct result.
